regs_console_port: RTL and testbench
====================================

// Module: regs_console_port
// PURPOSE
//  Console/debug master for the CPU register file: drives its read/write port (6-bit logical
//  address = reg[2:0], set bit[3], mode[5:4]) to examine/deposit single registers or dump all
//  15 physical locations. Sits between front-panel/debug command logic and the register file;
//  accesses the file only while the CPU grants it (cpu_halted).
// PARAMETERS
//  GNT_TIMEOUT  255  cycles to wait for cpu_halted per access before an error response
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  cmd_valid  in   1   command request
//  cmd_ready  out  1   command accepted when cmd_valid & cmd_ready
//  cmd_write  in   1   1 = deposit, 0 = examine
//  cmd_all    in   1   1 = dump all registers (cmd_write, cmd_addr ignored)
//  cmd_addr   in   6   logical register address
//  cmd_wdata  in   16  deposit data
//  rsp_valid  out  1   response valid; held until rsp_ready
//  rsp_ready  in   1   response consumed
//  rsp_addr   out  6   logical address of this response
//  rsp_data   out  16  read data (examine/dump), echoed wdata (deposit), 0 on error
//  rsp_err    out  1   illegal address or grant timeout
//  rsp_last   out  1   final response of command
//  cpu_halted in   1   grant: register file port owned by this block
//  rf_raddr   out  6   register file read address
//  rf_o       in   16  register file read data (combinational from rf_raddr)
//  rf_waddr   out  6   register file write address
//  rf_d       out  16  register file write data
//  rf_we      out  1   register file write enable
// BEHAVIOUR
//  States: IDLE, WAIT_GNT, ACCESS, RESP. cmd_ready = (state==IDLE).
//  Reset (any state): state=IDLE; rsp_valid, rsp_err, rsp_last, rf_we = 0; rsp_addr, rsp_data,
//   rf_raddr, rf_waddr, rf_d = 0; dump index and timeout counter = 0; pending command dropped,
//   no register write issued.
//  Accept edge T: latch cmd fields -> WAIT_GNT in T+1.
//  Illegal address (single cmd): addr[2:0]==3'b111, or addr[2:0]==3'b110 & addr[5:4]==2'b10.
//   -> goes straight to RESP (rsp_err=1, rsp_data=0, rsp_last=1); register file untouched.
//  WAIT_GNT: counter clears on entry; cpu_halted=1 -> ACCESS next cycle; counter reaching
//   GNT_TIMEOUT -> RESP with rsp_err=1, rsp_data=0 (dump: rsp_last=1, dump aborted).
//  ACCESS (one cycle): rf_raddr/rf_waddr = current addr at all times outside reset.
//   cpu_halted=1: read -> rsp_data <= rf_o; write -> rf_we=1 for exactly this cycle,
//   rf_d=wdata, rsp_data <= wdata; -> RESP. cpu_halted=0 -> back to WAIT_GNT, no access.
//  RESP: rsp_valid=1, fields stable until rsp_ready; on handshake: single -> IDLE;
//   dump not last -> index+1, WAIT_GNT (grant re-checked per entry); dump last -> IDLE.
//  Minimum latency: accept T, rsp_valid at T+3. rf_we never asserted outside ACCESS.
//  Dump order (index 0..14, 15 responses, rsp_last on index 14, never writes):
//   06'o00..06'o05 (set0 R0-R5), 06'o10..06'o15 (set1 R0-R5), 06'o06 KSP,
//   06'o26 SSP, 06'o66 USP. Index does not wrap; counter widths sized from GNT_TIMEOUT.
//  cmd_valid ignored while not IDLE; new cmd accepted in IDLE cycle after final handshake.
// TESTING
//  Deposit addr=06'o03 wdata=16'o123456, halted=1 -> rf_we one cycle at T+2, rf_waddr=06'o03,
//   rsp_valid T+3 data=16'o123456 err=0 last=1.
//  Examine addr=06'o66 with rf model USP=16'o001000 -> rsp_data=16'o001000, rf_we never high.
//  Dump with halted=1, rsp_ready=1 -> 15 responses in listed address order, last only on 15th.
//  Examine addr=06'o07 and 06'o46 -> err=1 data=0, rf never read-latched/written.
//  halted=0 for GNT_TIMEOUT cycles -> err=1 response; halted dropped in ACCESS -> retry, no write.
//  Reset asserted in WAIT_GNT and ACCESS of a deposit -> IDLE, rsp_valid=0, no rf_we pulse.

Source files
------------

// File: rtl/regs_console_port.sv
// Console/debug master for the CPU register file: examine, deposit or dump registers
// through the file's read/write port while the CPU grants access via cpu_halted.
module regs_console_port #(
  parameter int unsigned GNT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_all,
  input  logic [5:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [5:0]  rsp_addr,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_last,
  input  logic        cpu_halted,
  output logic [5:0]  rf_raddr,
  input  logic [15:0] rf_o,
  output logic [5:0]  rf_waddr,
  output logic [15:0] rf_d,
  output logic        rf_we
);

  localparam int unsigned CNT_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GNT_TIMEOUT - 1);
  localparam logic [3:0] LAST_IDX = 4'd14;

  typedef enum logic [1:0] {IDLE, WAIT_GNT, ACCESS, RESP} state_t;

  state_t             state, state_nxt;
  logic               cur_write, cur_all;
  logic [5:0]         cur_addr, eff_addr;
  logic [15:0]        cur_wdata;
  logic [3:0]         idx;
  logic [CNT_W-1:0]   cnt;
  logic               load_cmd, clr_cnt, inc_cnt, next_entry;
  logic               err_illegal, err_timeout, take_rsp, we_req;

  // Dump walks both general sets R0-R5, then the three stack pointers.
  function automatic logic [5:0] dump_addr(input logic [3:0] i);
    if (i < 4'd6)        return {3'b000, i[2:0]};
    else if (i < 4'd12)  return 6'(i + 4'd2);
    else if (i == 4'd12) return 6'o06;
    else if (i == 4'd13) return 6'o26;
    else                 return 6'o66;
  endfunction

  function automatic logic is_illegal(input logic [5:0] a);
    return (a[2:0] == 3'b111) || ((a[2:0] == 3'b110) && (a[5:4] == 2'b10));
  endfunction

  assign eff_addr  = cur_all ? dump_addr(idx) : cur_addr;
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Port drives are forced quiet during reset so an interrupted ACCESS never writes.
  assign rf_raddr = reset ? '0 : eff_addr;
  assign rf_waddr = reset ? '0 : eff_addr;
  assign rf_d     = reset ? '0 : cur_wdata;
  assign rf_we    = we_req & ~reset;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_cmd    = 1'b0;
    clr_cnt     = 1'b0;
    inc_cnt     = 1'b0;
    next_entry  = 1'b0;
    err_illegal = 1'b0;
    err_timeout = 1'b0;
    take_rsp    = 1'b0;
    we_req      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load_cmd = 1'b1;
          if (!cmd_all && is_illegal(cmd_addr)) begin
            err_illegal = 1'b1;
            state_nxt   = RESP;
          end else begin
            clr_cnt   = 1'b1;
            state_nxt = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        if (cpu_halted) begin
          state_nxt = ACCESS;
        end else if (cnt == CNT_LAST) begin
          err_timeout = 1'b1;
          state_nxt   = RESP;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      ACCESS: begin
        if (cpu_halted) begin
          take_rsp  = 1'b1;
          we_req    = cur_write;
          state_nxt = RESP;
        end else begin
          clr_cnt   = 1'b1;
          state_nxt = WAIT_GNT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          // Timeout responses carry last=1, so an aborted dump also ends here.
          if (cur_all && !rsp_last) begin
            next_entry = 1'b1;
            clr_cnt    = 1'b1;
            state_nxt  = WAIT_GNT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_write <= 1'b0;
      cur_all   <= 1'b0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      idx       <= '0;
      cnt       <= '0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      if (load_cmd) begin
        cur_all   <= cmd_all;
        cur_write <= cmd_write & ~cmd_all;
        cur_addr  <= cmd_addr;
        cur_wdata <= cmd_wdata;
        idx       <= '0;
      end
      if (clr_cnt)      cnt <= '0;
      else if (inc_cnt) cnt <= cnt + 1'b1;
      if (next_entry)   idx <= idx + 1'b1;
      if (err_illegal) begin
        rsp_addr <= cmd_addr;
        rsp_data <= '0;
        rsp_err  <= 1'b1;
        rsp_last <= 1'b1;
      end
      if (err_timeout) begin
        rsp_addr <= eff_addr;
        rsp_data <= '0;
        rsp_err  <= 1'b1;
        rsp_last <= 1'b1;
      end
      if (take_rsp) begin
        rsp_addr <= eff_addr;
        rsp_data <= cur_write ? cur_wdata : rf_o;
        rsp_err  <= 1'b0;
        rsp_last <= !cur_all || (idx == LAST_IDX);
      end
    end
  end

endmodule

// File: tb/tb_regs_console_port.sv
// Bench for regs_console_port: vector table, directed grant/reset corner cases and
// randomized commands checked against a register-file reference model.
module tb_regs_console_port;
  localparam int unsigned TO = 255;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, cmd_write, cmd_all;
  logic [5:0]  cmd_addr, rsp_addr, rf_raddr, rf_waddr;
  logic [15:0] cmd_wdata, rsp_data, rf_o, rf_d;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_last, cpu_halted, rf_we;

  always #5 clk = ~clk;

  regs_console_port #(.GNT_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_all(cmd_all), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_last(rsp_last), .cpu_halted(cpu_halted), .rf_raddr(rf_raddr),
    .rf_o(rf_o), .rf_waddr(rf_waddr), .rf_d(rf_d), .rf_we(rf_we)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [15:0] data;
    logic        err;
    logic        last;
  } resp_t;

  typedef struct {
    logic        w;
    logic        a;
    logic [5:0]  addr;
    logic [15:0] wd;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
  } vec_t;

  logic [15:0] rf_mem [64];
  logic [15:0] ref_rf [64];
  logic [5:0]  dump_order [15] = '{6'o00, 6'o01, 6'o02, 6'o03, 6'o04, 6'o05,
                                   6'o10, 6'o11, 6'o12, 6'o13, 6'o14, 6'o15,
                                   6'o06, 6'o26, 6'o66};
  resp_t       got_q[$], exp_q[$];
  vec_t        vecs[12];
  int          n_cmp = 0, n_bad = 0;
  int          we_count = 0, exp_we = 0;
  logic [5:0]  last_waddr;
  logic [15:0] last_wd;

  assign rf_o = rf_mem[rf_raddr];

  always @(posedge clk) begin
    if (rf_we) begin
      rf_mem[rf_waddr] <= rf_d;
      we_count         <= we_count + 1;
      last_waddr       <= rf_waddr;
      last_wd          <= rf_d;
      n_cmp = n_cmp + 1;
      if (!cpu_halted || reset) begin
        n_bad = n_bad + 1;
        $display("FAIL we_without_grant: halted=%0b reset=%0b required halted=1 reset=0",
                 cpu_halted, reset);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic halt_val(input int mode, input int e);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return ($urandom % 4) != 0;
      default: return (e == 0) || (e >= 4);
    endcase
  endfunction

  // Reference: what a command must produce, given the current register contents.
  task automatic model_cmd(input logic w, input logic a, input logic [5:0] ad, input logic [15:0] wd);
    resp_t r;
    exp_q.delete();
    exp_we = 0;
    if (a) begin
      for (int i = 0; i < 15; i++) begin
        r.addr = dump_order[i]; r.data = ref_rf[dump_order[i]]; r.err = 1'b0; r.last = (i == 14);
        exp_q.push_back(r);
      end
    end else if (ad[2:0] == 3'd7 || (ad[2:0] == 3'd6 && ad[5:4] == 2'd2)) begin
      r.addr = ad; r.data = '0; r.err = 1'b1; r.last = 1'b1;
      exp_q.push_back(r);
    end else begin
      if (w) begin
        ref_rf[ad] = wd;
        exp_we = 1;
      end
      r.addr = ad; r.data = ref_rf[ad]; r.err = 1'b0; r.last = 1'b1;
      exp_q.push_back(r);
    end
  endtask

  task automatic compare_resps(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_cmd(input logic w, input logic a, input logic [5:0] ad, input logic [15:0] wd,
                         input int mode, input bit stall, input int budget,
                         output int lat, output int we_lat);
    int    e, we_prev;
    bit    hold, rr;
    resp_t cur, held;
    got_q.delete();
    lat = -1; we_lat = -1; e = 0; hold = 0; held = '0;
    chk("ready_before_cmd", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_all = a; cmd_addr = ad; cmd_wdata = wd;
    cpu_halted = halt_val(mode, 0);
    we_prev = we_count;
    @(negedge clk);
    // keep requesting a bogus deposit while busy; it must be ignored
    cmd_write = 1'b1; cmd_all = 1'b0; cmd_addr = 6'($urandom); cmd_wdata = 16'($urandom);
    forever begin
      @(negedge clk);
      e++;
      if (we_count != we_prev) begin
        if (we_lat < 0) we_lat = e;
        we_prev = we_count;
      end
      chk("busy_not_ready", 32'(cmd_ready), 0);
      if (rsp_valid) begin
        cur.addr = rsp_addr; cur.data = rsp_data; cur.err = rsp_err; cur.last = rsp_last;
        if (hold) chk("rsp_hold_stable", 32'(cur), 32'(held));
        if (lat < 0) lat = e;
        rr = stall ? (($urandom % 3) != 0) : 1'b1;
        rsp_ready = rr;
        if (rr) begin
          got_q.push_back(cur);
          hold = 0;
          if (cur.last) begin
            cmd_valid = 1'b0;
            break;
          end
        end else begin
          hold = 1;
          held = cur;
        end
      end else begin
        rsp_ready = stall ? 1'($urandom % 2) : 1'b1;
      end
      if (e >= budget) begin
        n_cmp++; n_bad++;
        $display("FAIL cmd_budget: got no final response after %0d cycles required within %0d", e, budget);
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        break;
      end
      cpu_halted = halt_val(mode, e);
      if (mode == 3 && e == 1) begin
        #1;
        chk("we_in_ungranted_access", 32'(rf_we), 0);
      end
    end
    @(negedge clk);
    chk("valid_after_last", 32'(rsp_valid), 0);
    rsp_ready = 1'b0;
    cpu_halted = 1'b1;
  endtask

  initial begin
    int lat, wl, base;
    logic w, a;
    logic [5:0] ad;
    logic [15:0] wd;

    for (int i = 0; i < 64; i++) begin
      rf_mem[i] = 16'h1000 + 16'(i);
      ref_rf[i] = 16'h1000 + 16'(i);
    end
    vecs[0]  = '{1'b1, 1'b0, 6'o03, 16'o123456, 16'o123456, 1'b0, 2, 1};
    vecs[1]  = '{1'b0, 1'b0, 6'o03, 16'h0000,   16'o123456, 1'b0, 2, 0};
    vecs[2]  = '{1'b1, 1'b0, 6'o66, 16'o001000, 16'o001000, 1'b0, 2, 1};
    vecs[3]  = '{1'b0, 1'b0, 6'o66, 16'h0000,   16'o001000, 1'b0, 2, 0};
    vecs[4]  = '{1'b0, 1'b0, 6'o07, 16'h0000,   16'h0000,   1'b1, 1, 0};
    vecs[5]  = '{1'b0, 1'b0, 6'o46, 16'h0000,   16'h0000,   1'b1, 1, 0};
    vecs[6]  = '{1'b1, 1'b0, 6'o17, 16'hFFFF,   16'h0000,   1'b1, 1, 0};
    vecs[7]  = '{1'b1, 1'b0, 6'o36, 16'h55AA,   16'h55AA,   1'b0, 2, 1};
    vecs[8]  = '{1'b0, 1'b0, 6'o36, 16'h0000,   16'h55AA,   1'b0, 2, 0};
    vecs[9]  = '{1'b0, 1'b0, 6'o26, 16'h0000,   16'h1016,   1'b0, 2, 0};
    vecs[10] = '{1'b1, 1'b0, 6'o56, 16'h1234,   16'h0000,   1'b1, 1, 0};
    vecs[11] = '{1'b0, 1'b0, 6'o76, 16'h0000,   16'h103E,   1'b0, 2, 0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_all = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0; cpu_halted = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(rsp_valid), 0);
    chk("reset_ready", 32'(cmd_ready), 1);
    chk("reset_rsp_fields", 32'({rsp_addr, rsp_data, rsp_err, rsp_last}), 0);
    chk("reset_rf_port", 32'({rf_raddr, rf_waddr, rf_d, rf_we}), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      model_cmd(vecs[i].w, vecs[i].a, vecs[i].addr, vecs[i].wd);
      base = we_count;
      run_cmd(vecs[i].w, vecs[i].a, vecs[i].addr, vecs[i].wd, 0, 1'b0, 50, lat, wl);
      chk("vec_resp_count", 32'(got_q.size()), 1);
      if (got_q.size() >= 1) begin
        chk("vec_data", 32'(got_q[0].data), 32'(vecs[i].exp_data));
        chk("vec_err", 32'(got_q[0].err), 32'(vecs[i].exp_err));
        chk("vec_addr", 32'(got_q[0].addr), 32'(vecs[i].addr));
        chk("vec_last", 32'(got_q[0].last), 1);
      end
      chk("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
      chk("vec_writes", 32'(we_count - base), 32'(vecs[i].exp_wes));
      if (vecs[i].exp_wes != 0) begin
        chk("vec_we_cycle", 32'(wl), 2);
        chk("vec_waddr", 32'(last_waddr), 32'(vecs[i].addr));
        chk("vec_wdata", 32'(last_wd), 32'(vecs[i].wd));
      end
      compare_resps("vec_model");
    end

    model_cmd(1'b1, 1'b1, 6'o03, 16'hDEAD);
    base = we_count;
    run_cmd(1'b1, 1'b1, 6'o03, 16'hDEAD, 0, 1'b0, 200, lat, wl);
    compare_resps("dump_resp");
    chk("dump_latency", 32'(lat), 2);
    chk("dump_writes", 32'(we_count - base), 0);

    model_cmd(1'b0, 1'b0, 6'o02, 16'h0);
    run_cmd(1'b0, 1'b0, 6'o02, 16'h0, 1, 1'b0, 400, lat, wl);
    chk("timeout_latency", 32'(lat), TO);
    chk("timeout_count", 32'(got_q.size()), 1);
    if (got_q.size() >= 1) chk("timeout_resp", 32'(got_q[0]), 32'({6'o02, 16'h0, 1'b1, 1'b1}));

    base = we_count;
    run_cmd(1'b0, 1'b1, 6'o00, 16'h0, 1, 1'b0, 400, lat, wl);
    chk("dump_timeout_count", 32'(got_q.size()), 1);
    if (got_q.size() >= 1) chk("dump_timeout_resp", 32'(got_q[0]), 32'({6'o00, 16'h0, 1'b1, 1'b1}));
    chk("dump_timeout_writes", 32'(we_count - base), 0);

    model_cmd(1'b1, 1'b0, 6'o12, 16'h0F0F);
    base = we_count;
    run_cmd(1'b1, 1'b0, 6'o12, 16'h0F0F, 3, 1'b0, 50, lat, wl);
    compare_resps("drop_retry_resp");
    chk("drop_retry_latency", 32'(lat), 6);
    chk("drop_retry_we_cycle", 32'(wl), 6);
    chk("drop_retry_writes", 32'(we_count - base), 1);

    // Reset while waiting for grant on a deposit.
    base = we_count;
    cpu_halted = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_all = 1'b0; cmd_addr = 6'o05; cmd_wdata = 16'hBEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstwait_valid", 32'(rsp_valid), 0);
    chk("rstwait_fields", 32'({rsp_addr, rsp_data, rsp_err, rsp_last, rf_waddr, rf_d}), 0);
    reset = 1'b0; cpu_halted = 1'b1;
    @(negedge clk);
    chk("rstwait_idle", 32'(cmd_ready), 1);
    repeat (4) @(negedge clk);
    chk("rstwait_no_resp", 32'(rsp_valid), 0);
    chk("rstwait_writes", 32'(we_count - base), 0);
    chk("rstwait_rf", 32'(rf_mem[6'o05]), 32'(ref_rf[6'o05]));

    // Reset landing on the ACCESS cycle of a deposit.
    base = we_count;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_all = 1'b0; cmd_addr = 6'o04; cmd_wdata = 16'hCAFE;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstacc_we_low", 32'(rf_we), 0);
    @(negedge clk);
    chk("rstacc_valid", 32'(rsp_valid), 0);
    chk("rstacc_fields", 32'({rsp_addr, rsp_data, rsp_err, rsp_last, rf_raddr}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstacc_idle", 32'(cmd_ready), 1);
    repeat (4) @(negedge clk);
    chk("rstacc_no_resp", 32'(rsp_valid), 0);
    chk("rstacc_writes", 32'(we_count - base), 0);
    chk("rstacc_rf", 32'(rf_mem[6'o04]), 32'(ref_rf[6'o04]));

    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom % 2);
      a = (($urandom % 7) == 0);
      ad = 6'($urandom);
      wd = 16'($urandom);
      model_cmd(w, a, ad, wd);
      base = we_count;
      run_cmd(w, a, ad, wd, 2, 1'b1, 3000, lat, wl);
      compare_resps("rand_resp");
      chk("rand_writes", 32'(we_count - base), 32'(exp_we));
    end

    for (int i = 0; i < 64; i++) chk("rf_final", 32'(rf_mem[i]), 32'(ref_rf[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
